// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: frames an encoded SB message into a 64-bit packet,
// shifts it out LSB-first, then holds a 32-cycle gap. Optional parity: SB_TX_PARITY_EN.
`timescale 1ns/1ps
module sb_tx_serializer #(
  parameter int SB_MSG_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
  input  logic [2:0]              i_tx_msg_info,
  output logic                    o_SB_Busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_sb_tx_data,
  output logic                    o_sb_tx_clk_en,
  output logic                    o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_GAP  = 3'd2,
    S_DONE = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic [4:0]  r_gap_cnt;
  logic        r_valid_d;
  logic        r_overrun;
  logic        w_accept;
  logic        w_cp;
  logic [7:0]  w_msgcode;
  logic [63:0] w_packet;

  // Handshake: the request is a level; it is taken (accept) only in IDLE while
  // i_tx_msg_valid=1. There is no ready output: o_SB_Busy and the DONE pulse
  // tell upstream when to drop or change its request.
  assign w_accept = (r_state == S_IDLE) && i_tx_msg_valid;

  always_comb begin
    w_msgcode = '0;
    w_msgcode[SB_MSG_WIDTH-1:0] = i_encoded_SB_msg;
  end

`ifdef SB_TX_PARITY_EN
  // Only the opcode, msgcode and info fields can be non-zero below bit 62.
  assign w_cp = ^{i_tx_msg_info, w_msgcode, 5'b10010};
`else
  assign w_cp = 1'b0;
`endif

  assign w_packet = {1'b0, w_cp, 27'd0, i_tx_msg_info, 10'd0, w_msgcode, 9'd0, 5'b10010};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_SEND;
      S_SEND: if (r_bit_cnt == 6'd63) w_next = S_GAP;
      S_GAP:  if (r_gap_cnt == 5'd31) w_next = S_DONE;
      S_DONE: w_next = S_HOLD;
      S_HOLD: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_valid_d <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_valid_d <= i_tx_msg_valid;

      if (w_accept) begin
        r_shift <= w_packet;
      end else if (r_state == S_SEND) begin
        r_shift <= {1'b0, r_shift[63:1]};
      end

      if (r_state == S_SEND && r_bit_cnt != 6'd63) begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end else begin
        r_bit_cnt <= '0;
      end

      if (r_state == S_GAP && r_gap_cnt != 5'd31) begin
        r_gap_cnt <= r_gap_cnt + 5'd1;
      end else begin
        r_gap_cnt <= '0;
      end

      // A fresh request edge while busy would otherwise be silently lost.
      if (i_tx_msg_valid && !r_valid_d && (r_state == S_SEND || r_state == S_GAP)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_SB_Busy           = (r_state == S_SEND) || (r_state == S_GAP);
  assign o_falling_edge_busy = (r_state == S_DONE);
  assign o_sb_tx_clk_en      = (r_state == S_SEND);
  assign o_sb_tx_data        = (r_state == S_SEND) && r_shift[0];
  assign o_overrun           = r_overrun;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: random requests, serial stream captured by a
// monitor and compared with packets built from the field layout.
`timescale 1ns/1ps
module tb_sb_tx_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] msg = '0;
  logic [2:0]   info = '0;
  logic         busy, pulse, data, clk_en, overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  sb_tx_serializer #(.SB_MSG_WIDTH(W)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_tx_msg_valid      (valid),
    .i_encoded_SB_msg    (msg),
    .i_tx_msg_info       (info),
    .o_SB_Busy           (busy),
    .o_falling_edge_busy (pulse),
    .o_sb_tx_data        (data),
    .o_sb_tx_clk_en      (clk_en),
    .o_overrun           (overrun)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: rebuilds packets from the serial stream
  logic [63:0] pkt_q[$];
  int          start_q[$];
  int          pulse_q[$];
  int          busy_cnt, busy_first, busy_last, stray_data, bit_i;
  logic [63:0] cur;

  initial begin
    bit_i = 0; cur = '0; busy_cnt = 0; busy_first = -1; busy_last = -1; stray_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bit_i = 0;
      end else begin
        if (clk_en) begin
          if (bit_i == 0) start_q.push_back(cyc);
          cur[bit_i] = data;
          bit_i++;
          if (bit_i == 64) begin
            pkt_q.push_back(cur);
            bit_i = 0;
          end
        end else if (data) begin
          stray_data++;
        end
        if (pulse) pulse_q.push_back(cyc);
        if (busy) begin
          if (busy_cnt == 0) busy_first = cyc;
          busy_last = cyc;
          busy_cnt++;
        end
      end
    end
  end

  // reference model: packet assembled from its field values
  function automatic logic [63:0] exp_packet(input logic [W-1:0] m, input logic [2:0] inf);
    logic [63:0] p;
    p = 64'd18 + (64'(m) << 14) + (64'(inf) << 32);
`ifdef SB_TX_PARITY_EN
    p[62] = ($countones(p[61:0]) % 2) == 1;
`endif
    return p;
  endfunction

  // driver tasks
  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) wait_clk();
  endtask

  task automatic clear_mon();
    pkt_q.delete(); start_q.delete(); pulse_q.delete();
    busy_cnt = 0; busy_first = -1; busy_last = -1; stray_data = 0;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2);
    clear_mon();
  endtask

  // request valid for one cycle; t is the accept cycle
  task automatic send_one(input logic [W-1:0] m, input logic [2:0] inf, output int t);
    msg = m; info = inf; valid = 1'b1;
    t = cyc;
    wait_clk();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    if ({busy, pulse, data, clk_en, overrun} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 00000", {busy, pulse, data, clk_en, overrun});
    end
    n_vec++;
    run(2);
    rst_n = 1'b1;
    run(3);
    if ({busy, pulse, data, clk_en, overrun} !== 5'b0) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected 00000", {busy, pulse, data, clk_en, overrun});
    end
    n_vec++;
    clear_mon();
  endtask

  task automatic test_single();
    int t;
    logic [63:0] p;
    do_reset();
    send_one(4'h5, 3'b010, t);
    run(105);
    if (pkt_q.size() !== 1) begin
      n_err++; $display("FAIL single_pkt_count: got %0d expected 1", pkt_q.size());
    end
    n_vec++;
    p = (pkt_q.size() > 0) ? pkt_q[0] : 64'd0;
    if (p[4:0] !== 5'b10010) begin
      n_err++; $display("FAIL single_opcode: got %b expected 10010", p[4:0]);
    end
    n_vec++;
    if (p[21:14] !== 8'h05) begin
      n_err++; $display("FAIL single_msgcode: got %h expected 05", p[21:14]);
    end
    n_vec++;
    if (p[34:32] !== 3'b010) begin
      n_err++; $display("FAIL single_info: got %b expected 010", p[34:32]);
    end
    n_vec++;
    if (p !== exp_packet(4'h5, 3'b010)) begin
      n_err++; $display("FAIL single_packet: got %h expected %h", p, exp_packet(4'h5, 3'b010));
    end
    n_vec++;
    if (start_q.size() == 0 || start_q[0] !== t + 1) begin
      n_err++; $display("FAIL single_start: got %0d expected %0d", (start_q.size() > 0) ? start_q[0] - t : -1, 1);
    end
    n_vec++;
    if (busy_cnt !== 96 || busy_first !== t + 1 || busy_last !== t + 96) begin
      n_err++; $display("FAIL single_busy: got %0d cycles from t+%0d to t+%0d expected 96 from t+1 to t+96",
                        busy_cnt, busy_first - t, busy_last - t);
    end
    n_vec++;
    if (pulse_q.size() !== 1 || pulse_q[0] !== t + 97) begin
      n_err++; $display("FAIL single_pulse: got %0d pulses first at t+%0d expected 1 at t+97",
                        pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] - t : -1);
    end
    n_vec++;
    if (stray_data !== 0) begin
      n_err++; $display("FAIL single_stray_data: got %0d expected 0", stray_data);
    end
    n_vec++;
  endtask

  task automatic test_parity();
    int t;
    logic [63:0] p;
    logic        exp_cp;
`ifdef SB_TX_PARITY_EN
    exp_cp = 1'b1;
`else
    exp_cp = 1'b0;
`endif
    do_reset();
    send_one(4'h3, 3'b001, t);
    run(105);
    p = (pkt_q.size() > 0) ? pkt_q[0] : 64'd0;
    if (p[62] !== exp_cp) begin
      n_err++; $display("FAIL parity_bit: got %b expected %b", p[62], exp_cp);
    end
    n_vec++;
    if (p !== exp_packet(4'h3, 3'b001) || pkt_q.size() !== 1) begin
      n_err++; $display("FAIL parity_packet: got %h expected %h", p, exp_packet(4'h3, 3'b001));
    end
    n_vec++;
  endtask

  task automatic test_random();
    int t;
    logic [W-1:0] m;
    logic [2:0]   inf;
    logic [63:0]  p;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      m = W'($urandom_range(0, (1 << W) - 1));
      inf = 3'($urandom_range(0, 7));
      clear_mon();
      send_one(m, inf, t);
      run(100);
      p = (pkt_q.size() > 0) ? pkt_q[0] : 64'd0;
      if (pkt_q.size() !== 1 || p !== exp_packet(m, inf) || pulse_q.size() !== 1) begin
        n_err++; $display("FAIL random_packet_%0d: got %h (%0d pkts, %0d pulses) expected %h (1, 1)",
                          k, p, pkt_q.size(), pulse_q.size(), exp_packet(m, inf));
      end
      n_vec++;
    end
  endtask

  task automatic test_input_change();
    int t;
    logic [W-1:0] m;
    logic [2:0]   inf;
    logic [63:0]  p;
    do_reset();
    m = W'($urandom_range(0, (1 << W) - 1));
    inf = 3'($urandom_range(0, 7));
    send_one(m, inf, t);
    run(9);
    msg = ~m;
    info = ~inf;
    run(95);
    p = (pkt_q.size() > 0) ? pkt_q[0] : 64'd0;
    if (pkt_q.size() !== 1 || p !== exp_packet(m, inf)) begin
      n_err++; $display("FAIL input_change_packet: got %h expected %h", p, exp_packet(m, inf));
    end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    int t;
    logic [W-1:0] m;
    logic [2:0]   inf;
    logic [63:0]  e;
    do_reset();
    m = W'($urandom_range(0, (1 << W) - 1));
    inf = 3'($urandom_range(0, 7));
    e = exp_packet(m, inf);
    msg = m; info = inf; valid = 1'b1;
    t = cyc;
    run(199);
    valid = 1'b0;
    run(105);
    if (pkt_q.size() !== 3) begin
      n_err++; $display("FAIL b2b_pkt_count: got %0d expected 3", pkt_q.size());
    end
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      if (k >= start_q.size() || start_q[k] !== t + 1 + 99 * k) begin
        n_err++; $display("FAIL b2b_start_%0d: got t+%0d expected t+%0d",
                          k, (k < start_q.size()) ? start_q[k] - t : -1, 1 + 99 * k);
      end
      n_vec++;
      if (k >= pulse_q.size() || pulse_q[k] !== t + 97 + 99 * k) begin
        n_err++; $display("FAIL b2b_pulse_%0d: got t+%0d expected t+%0d",
                          k, (k < pulse_q.size()) ? pulse_q[k] - t : -1, 97 + 99 * k);
      end
      n_vec++;
      if (k >= pkt_q.size() || pkt_q[k] !== e) begin
        n_err++; $display("FAIL b2b_packet_%0d: got %h expected %h", k, (k < pkt_q.size()) ? pkt_q[k] : 64'd0, e);
      end
      n_vec++;
    end
    if (pulse_q.size() !== 3) begin
      n_err++; $display("FAIL b2b_pulse_count: got %0d expected 3", pulse_q.size());
    end
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL b2b_overrun: got %b expected 0", overrun);
    end
    n_vec++;
  endtask

  task automatic test_overrun();
    int t;
    logic [W-1:0] m;
    logic [2:0]   inf;
    logic [63:0]  p;
    do_reset();
    m = W'($urandom_range(0, (1 << W) - 1));
    inf = 3'($urandom_range(0, 7));
    send_one(m, inf, t);
    run(29);
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_before: got %b expected 0", overrun);
    end
    n_vec++;
    msg = ~m; info = ~inf; valid = 1'b1;
    wait_clk();
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    n_vec++;
    valid = 1'b0;
    run(90);
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
    n_vec++;
    p = (pkt_q.size() > 0) ? pkt_q[0] : 64'd0;
    if (pkt_q.size() !== 1 || p !== exp_packet(m, inf) || pulse_q.size() !== 1) begin
      n_err++; $display("FAIL overrun_packet: got %h (%0d pkts, %0d pulses) expected %h (1, 1)",
                        p, pkt_q.size(), pulse_q.size(), exp_packet(m, inf));
    end
    n_vec++;
    do_reset();
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_cleared: got %b expected 0", overrun);
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    int t;
    logic [W-1:0] m;
    logic [2:0]   inf;
    logic [63:0]  p;
    do_reset();
    send_one(W'($urandom_range(0, (1 << W) - 1)), 3'($urandom_range(0, 7)), t);
    run(39);
    rst_n = 1'b0;
    #1;
    if ({busy, pulse, data, clk_en, overrun} !== 5'b0) begin
      n_err++; $display("FAIL midreset_outputs: got %b expected 00000", {busy, pulse, data, clk_en, overrun});
    end
    n_vec++;
    run(2);
    rst_n = 1'b1;
    run(110);
    if (pulse_q.size() !== 0 || pkt_q.size() !== 0) begin
      n_err++; $display("FAIL midreset_no_pulse: got %0d pulses %0d pkts expected 0 0", pulse_q.size(), pkt_q.size());
    end
    n_vec++;
    clear_mon();
    m = W'($urandom_range(0, (1 << W) - 1));
    inf = 3'($urandom_range(0, 7));
    send_one(m, inf, t);
    run(100);
    p = (pkt_q.size() > 0) ? pkt_q[0] : 64'd0;
    if (pkt_q.size() !== 1 || p !== exp_packet(m, inf) || pulse_q.size() !== 1) begin
      n_err++; $display("FAIL midreset_next_packet: got %h (%0d pkts, %0d pulses) expected %h (1, 1)",
                        p, pkt_q.size(), pulse_q.size(), exp_packet(m, inf));
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_random();
    test_input_change();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
